// File: rtl/line_buf_addr_gen_pkg.sv
// Shared defaults and helpers for the line-buffer address generator.
// Holds the default geometry, the read-threshold derivation and a
// modulo-add used by both the pointer counters and the tap decoder.
package line_buf_addr_pkg;

  localparam int unsigned DEFAULT_DEPTH  = 15;
  localparam int unsigned DEFAULT_TAPS   = 3;
  localparam int unsigned DEFAULT_STRIDE = 3;

  // A read needs enough data for the whole stride and for the taps at or
  // ahead of the centre tap, whichever is larger.
  function automatic int unsigned rd_need(input int unsigned stride,
                                          input int unsigned taps);
    int unsigned ahead;
    ahead = taps - taps / 2;
    return (stride > ahead) ? stride : ahead;
  endfunction

  // Modulo add for operands already reduced below m; one conditional
  // subtract is enough, so unused codes above m-1 are never produced.
  function automatic int unsigned mod_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/line_buf_addr_gen_counter.sv
// Modulo-DEPTH counter that advances by STEP when enabled.
// Synchronous reset has priority over the synchronous clear.
module mod_step_counter
  import line_buf_addr_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] count_o
);

  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  // Next count: wrap exactly at DEPTH, hold when not enabled.
  always_comb begin
    count_d = count_q;
    if (en_i) count_d = AW'(mod_add(32'(count_q), STEP, DEPTH));
  end

  // Count register with reset and soft clear both returning to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i)      count_q <= '0;
    else if (clr_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/line_buf_addr_gen.sv
// Line-buffer address generator: write pointer, strided multi-tap read
// base, fill tracking and wrap pulse.
// Optional sticky protocol-error flag enabled by LINE_BUF_ADDR_GEN_ERR_EN;
// without it err_o is tied low.
module line_buf_addr_gen
  import line_buf_addr_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned TAPS   = DEFAULT_TAPS,
  parameter int unsigned STRIDE = DEFAULT_STRIDE,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  output logic [AW-1:0]      wr_addr_o,
  output logic [TAPS*AW-1:0] rd_addr_o,
  output logic               rd_ok_o,
  output logic               full_o,
  output logic [AW:0]        fill_o,
  output logic               wr_wrap_o,
  output logic               err_o
);

  localparam int unsigned RD_NEED    = rd_need(STRIDE, TAPS);
  localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [AW:0] STRIDE_W   = (AW+1)'(STRIDE);
  localparam logic [AW:0] RD_NEED_W  = (AW+1)'(RD_NEED);
  localparam logic [AW:0] ONE_W      = (AW+1)'(1);
  localparam logic [AW-1:0] LAST_W   = AW'(DEPTH - 1);

  if ((TAPS % 2) == 0 || DEPTH < TAPS || STRIDE < 1 || STRIDE > DEPTH) begin : g_bad_params
    $error("line_buf_addr_gen: illegal DEPTH/TAPS/STRIDE combination");
  end

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] base;
  logic [AW:0]   fill_q;
  logic [AW:0]   fill_d;
  logic          wr_wrap_q;
  logic          full;
  logic          rd_ok;
  logic          wr_acc;
  logic          rd_acc;

  assign full   = (fill_q == DEPTH_W);
  assign rd_ok  = (fill_q >= RD_NEED_W);
  assign wr_acc = wr_en_i & ~full;
  assign rd_acc = rd_en_i & rd_ok;

  mod_step_counter #(.DEPTH(DEPTH), .STEP(1), .AW(AW)) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .en_i    (wr_acc),
    .count_o (wr_addr)
  );

  mod_step_counter #(.DEPTH(DEPTH), .STEP(STRIDE), .AW(AW)) u_rd_base (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .en_i    (rd_acc),
    .count_o (base)
  );

  // Each tap sits at a fixed offset around the base, centred on tap TAPS/2.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    localparam int unsigned OFFS = (t + DEPTH - TAPS / 2) % DEPTH;
    assign rd_addr_o[t*AW +: AW] = AW'(mod_add(32'(base), OFFS, DEPTH));
  end

  // Fill update: a write and a read accepted together both apply.
  always_comb begin
    fill_d = fill_q;
    if (wr_acc) fill_d = fill_d + ONE_W;
    if (rd_acc) fill_d = fill_d - STRIDE_W;
  end

  // Fill register and the one-cycle wrap pulse after writing the last slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      fill_q    <= '0;
      wr_wrap_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      wr_wrap_q <= wr_acc && (wr_addr == LAST_W);
    end
  end

`ifdef LINE_BUF_ADDR_GEN_ERR_EN
  logic err_q;

  // Sticky error on a write into a full buffer or a read below threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      err_q <= 1'b0;
    else if (clr_i)                                 err_q <= 1'b0;
    else if ((wr_en_i && full) || (rd_en_i && !rd_ok)) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign wr_addr_o = wr_addr;
  assign rd_ok_o   = rd_ok;
  assign full_o    = full;
  assign fill_o    = fill_q;
  assign wr_wrap_o = wr_wrap_q;

endmodule
